// File: rtl/fractcam_pkg.sv
// Shared types and helpers for the FracTCAM update controller.
// Optional macro: FRACTCAM_INIT_CLEAR_EN adds the post-reset CLEAR state.
package fractcam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP
`ifdef FRACTCAM_INIT_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam int unsigned MAX_KEY_W   = 256;
  localparam int unsigned MAX_SLICE_W = 16;

  // Returns slice s (w bits wide) of vec, zero-extended to MAX_SLICE_W.
  function automatic logic [MAX_SLICE_W-1:0] slice_of(input logic [MAX_KEY_W-1:0] vec,
                                                      input int unsigned s,
                                                      input int unsigned w);
    return MAX_SLICE_W'(vec >> (s * w)) &
           ((MAX_SLICE_W'(1) << w) - MAX_SLICE_W'(1));
  endfunction

endpackage

// File: rtl/fractcam_slice_enc.sv
// Combinational per-slice match-bit encoder for one LUT-RAM address.
// Optional macro: none (FRACTCAM_INIT_CLEAR_EN affects only the top).
module fractcam_slice_enc
  import fractcam_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int SLICES = 8
) (
  input  logic [WIDTH-1:0]        addr,
  input  logic [WIDTH*SLICES-1:0] key,
  input  logic [WIDTH*SLICES-1:0] mask,
  input  logic                    op,
  output logic [SLICES-1:0]       tbl_wr_data
);

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [MAX_SLICE_W-1:0] k;
    logic [MAX_SLICE_W-1:0] m;
    assign k = slice_of(MAX_KEY_W'(key), s, WIDTH);
    assign m = slice_of(MAX_KEY_W'(mask), s, WIDTH);
    assign tbl_wr_data[s] = (op == OP_WRITE) &&
                            (((MAX_SLICE_W'(addr) ^ k) & m) == '0);
  end

endmodule

// File: rtl/fractcam_upd_ctrl.sv
// FracTCAM update controller: expands entry write/delete into a LUT-RAM column sweep.
// Optional macro: FRACTCAM_INIT_CLEAR_EN (zero every entry after reset).
module fractcam_upd_ctrl
  import fractcam_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int SLICES = 8,
  parameter int DEPTH  = 64,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_op,
  input  logic [IDX_W-1:0]        req_idx,
  input  logic [WIDTH*SLICES-1:0] req_key,
  input  logic [WIDTH*SLICES-1:0] req_mask,
  output logic                    done,
  output logic                    tbl_wr_en,
  output logic [IDX_W-1:0]        tbl_wr_idx,
  output logic [WIDTH-1:0]        tbl_wr_addr,
  output logic [SLICES-1:0]       tbl_wr_data,
  output logic                    lkp_block
);

  state_t                  state;
  logic                    op_q;
  logic [WIDTH*SLICES-1:0] key_q;
  logic [WIDTH*SLICES-1:0] mask_q;

  logic [WIDTH-1:0]        enc_addr;
  logic [WIDTH*SLICES-1:0] enc_key;
  logic [WIDTH*SLICES-1:0] enc_mask;
  logic                    enc_op;
  logic [SLICES-1:0]       enc_data;

  // The encoder computes the data for the next registered write: address 0 of the
  // incoming request while idle, otherwise the following address of the held entry.
  always_comb begin
    enc_addr = tbl_wr_addr + WIDTH'(1);
    enc_key  = key_q;
    enc_mask = mask_q;
    enc_op   = op_q;
    if (state == IDLE) begin
      enc_addr = '0;
      enc_key  = req_key;
      enc_mask = req_mask;
      enc_op   = req_op;
    end
  end

  fractcam_slice_enc #(
    .WIDTH  (WIDTH),
    .SLICES (SLICES)
  ) u_enc (
    .addr        (enc_addr),
    .key         (enc_key),
    .mask        (enc_mask),
    .op          (enc_op),
    .tbl_wr_data (enc_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef FRACTCAM_INIT_CLEAR_EN
      state     <= CLEAR;
      req_ready <= 1'b0;
`else
      state     <= IDLE;
      req_ready <= 1'b1;
`endif
      done        <= 1'b0;
      tbl_wr_en   <= 1'b0;
      tbl_wr_idx  <= '0;
      tbl_wr_addr <= '0;
      tbl_wr_data <= '0;
      lkp_block   <= 1'b0;
      op_q        <= OP_WRITE;
      key_q       <= '0;
      mask_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q        <= req_op;
            key_q       <= req_key;
            mask_q      <= req_mask;
            tbl_wr_idx  <= req_idx;
            tbl_wr_addr <= '0;
            tbl_wr_data <= enc_data;
            tbl_wr_en   <= 1'b1;
            lkp_block   <= 1'b1;
            req_ready   <= 1'b0;
            state       <= SWEEP;
          end
        end
        SWEEP: begin
          if (tbl_wr_addr == '1) begin
            tbl_wr_en   <= 1'b0;
            lkp_block   <= 1'b0;
            tbl_wr_data <= '0;
            req_ready   <= 1'b1;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            tbl_wr_addr <= enc_addr;
            tbl_wr_data <= enc_data;
          end
        end
`ifdef FRACTCAM_INIT_CLEAR_EN
        // First CLEAR cycle after reset only arms the strobe; the sweep follows.
        CLEAR: begin
          tbl_wr_data <= '0;
          if (!tbl_wr_en) begin
            tbl_wr_en   <= 1'b1;
            lkp_block   <= 1'b1;
            tbl_wr_idx  <= '0;
            tbl_wr_addr <= '0;
          end else if (tbl_wr_addr == '1 && tbl_wr_idx == IDX_W'(DEPTH - 1)) begin
            tbl_wr_en <= 1'b0;
            lkp_block <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (tbl_wr_addr == '1) begin
            tbl_wr_addr <= '0;
            tbl_wr_idx  <= tbl_wr_idx + IDX_W'(1);
          end else begin
            tbl_wr_addr <= tbl_wr_addr + WIDTH'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fractcam_upd_ctrl.sv
// Directed self-checking bench for fractcam_upd_ctrl (WIDTH=5, SLICES=8, DEPTH=64).
// Optional macro: FRACTCAM_INIT_CLEAR_EN enables the post-reset clear scenario.
module tb_fractcam_upd_ctrl;

  localparam int WIDTH  = 5;
  localparam int SLICES = 8;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int NADDR  = 32;
`ifdef FRACTCAM_INIT_CLEAR_EN
  localparam logic RDY_AFTER_RST = 1'b0;
`else
  localparam logic RDY_AFTER_RST = 1'b1;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_op;
  logic [IDX_W-1:0]        req_idx;
  logic [WIDTH*SLICES-1:0] req_key;
  logic [WIDTH*SLICES-1:0] req_mask;
  logic                    done;
  logic                    tbl_wr_en;
  logic [IDX_W-1:0]        tbl_wr_idx;
  logic [WIDTH-1:0]        tbl_wr_addr;
  logic [SLICES-1:0]       tbl_wr_data;
  logic                    lkp_block;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fractcam_upd_ctrl #(
    .WIDTH  (WIDTH),
    .SLICES (SLICES),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_idx     (req_idx),
    .req_key     (req_key),
    .req_mask    (req_mask),
    .done        (done),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .lkp_block   (lkp_block)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then presents one request for one cycle.
  task automatic send_req(input logic op, input logic [IDX_W-1:0] idx,
                          input logic [WIDTH*SLICES-1:0] key, input logic [WIDTH*SLICES-1:0] mask);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 5000) begin
      tick();
      waited++;
    end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait: req_ready=%b required 1 within 5000 cycles", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = idx;
    req_key   = key;
    req_mask  = mask;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] obs, exp;
    rst = 1'b1;
    repeat (3) tick();
    obs = {tbl_wr_en, lkp_block, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data};
    exp = {1'b0, 1'b0, RDY_AFTER_RST, 1'b0, 6'd0, 5'd0, 8'd0};
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, exp);
    end
    rst = 1'b0;
`ifndef FRACTCAM_INIT_CLEAR_EN
    tick();
    n_chk++;
    if ({req_ready, tbl_wr_en, lkp_block, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy/en/blk/done=%b required 1000",
               {req_ready, tbl_wr_en, lkp_block, done});
    end
`endif
  endtask

`ifdef FRACTCAM_INIT_CLEAR_EN
  task automatic test_init_clear();
    logic [27:0] obs, exp;
    for (int c = 1; c <= DEPTH * NADDR; c++) begin
      tick();
      obs = {tbl_wr_en, lkp_block, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 6'((c - 1) / NADDR), 5'((c - 1) % NADDR), 8'h00};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL init_clear_c%0d: got %h required %h", c, obs, exp);
      end
    end
    tick();
    n_chk++;
    if ({req_ready, done, tbl_wr_en, lkp_block} !== 4'b1100) begin
      n_fail++;
      $display("FAIL init_clear_done: rdy/done/en/blk=%b required 1100",
               {req_ready, done, tbl_wr_en, lkp_block});
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_clear_done_once: done=%b required 0", done);
    end
  endtask
`endif

  // Slice0 exact key 0x0A, other slices wildcard (non-zero keys must be ignored).
  task automatic test_write_single();
    logic [27:0] obs, exp;
    send_req(1'b0, 6'd3, 40'hFEDCBA984A, 40'h000000001F);
    for (int a = 0; a < NADDR; a++) begin
      obs = {tbl_wr_en, lkp_block, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 5'(a), 7'h7F, (a == 10)};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL write_single_a%0d: got %h required %h", a, obs, exp);
      end
      tick();
    end
    n_chk++;
    if ({done, req_ready, tbl_wr_en, lkp_block} !== 4'b1100) begin
      n_fail++;
      $display("FAIL write_single_done: done/rdy/en/blk=%b required 1100",
               {done, req_ready, tbl_wr_en, lkp_block});
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL write_single_done_pulse: done=%b required 0", done);
    end
  endtask

  // Only the MSB of slice0 is cared about: upper half of the column matches.
  task automatic test_write_halfmask();
    logic [27:0] obs, exp;
    send_req(1'b0, 6'd0, 40'h0000000010, 40'h0000000010);
    for (int a = 0; a < NADDR; a++) begin
      obs = {tbl_wr_en, lkp_block, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 5'(a), 7'h7F, (a >= 16)};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL write_halfmask_a%0d: got %h required %h", a, obs, exp);
      end
      tick();
    end
    tick();
  endtask

  // Full mask on every slice, slice s key = 4*s+1: one set address per slice.
  task automatic test_write_exact();
    logic [WIDTH*SLICES-1:0] key;
    logic [SLICES-1:0]       exp;
    for (int s = 0; s < SLICES; s++) key[s*WIDTH +: WIDTH] = 5'(s * 4 + 1);
    send_req(1'b0, 6'd17, key, '1);
    for (int a = 0; a < NADDR; a++) begin
      for (int s = 0; s < SLICES; s++) exp[s] = (a == s * 4 + 1);
      n_chk++;
      if (tbl_wr_data !== exp || tbl_wr_addr !== 5'(a) || tbl_wr_idx !== 6'd17) begin
        n_fail++;
        $display("FAIL write_exact_a%0d: data=%h addr=%h idx=%h required data=%h addr=%h idx=11",
                 a, tbl_wr_data, tbl_wr_addr, tbl_wr_idx, exp, 5'(a));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_delete();
    int n_en = 0, n_blk = 0, n_done = 0;
    send_req(1'b1, 6'd63, '1, '1);
    for (int i = 0; i < 40; i++) begin
      if (tbl_wr_en === 1'b1) begin
        n_chk++;
        if (tbl_wr_idx !== 6'd63 || tbl_wr_data !== 8'h00 || tbl_wr_addr !== 5'(n_en)) begin
          n_fail++;
          $display("FAIL delete_write%0d: idx=%h data=%h addr=%h required idx=3f data=00 addr=%h",
                   n_en, tbl_wr_idx, tbl_wr_data, tbl_wr_addr, 5'(n_en));
        end
        n_en++;
      end
      if (lkp_block === 1'b1) n_blk++;
      if (done === 1'b1) n_done++;
      tick();
    end
    n_chk++;
    if (n_en != 32 || n_blk != 32 || n_done != 1) begin
      n_fail++;
      $display("FAIL delete_counts: writes=%0d block=%0d done=%0d required 32 32 1",
               n_en, n_blk, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_idx   = 6'd5;
    req_key   = 40'h0000000003;
    req_mask  = 40'h000000001F;
    while (req_ready !== 1'b1 && waited < 5000) begin
      tick();
      waited++;
    end
    tick();
    req_op  = 1'b1;
    req_idx = 6'd9;
    for (int a = 0; a < NADDR; a++) begin
      n_chk++;
      if ({tbl_wr_en, req_ready, tbl_wr_idx, tbl_wr_addr, tbl_wr_data} !==
          {1'b1, 1'b0, 6'd5, 5'(a), 7'h7F, (a == 3)}) begin
        n_fail++;
        $display("FAIL b2b_first_a%0d: en=%b rdy=%b idx=%h addr=%h data=%h required en=1 rdy=0 idx=05",
                 a, tbl_wr_en, req_ready, tbl_wr_idx, tbl_wr_addr, tbl_wr_data);
      end
      tick();
    end
    n_chk++;
    if ({done, req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_done_ready: done/rdy=%b required 11", {done, req_ready});
    end
    tick();
    req_valid = 1'b0;
    for (int a = 0; a < NADDR; a++) begin
      n_chk++;
      if ({tbl_wr_en, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data} !==
          {1'b1, 1'b0, 1'b0, 6'd9, 5'(a), 8'h00}) begin
        n_fail++;
        $display("FAIL b2b_second_a%0d: en=%b rdy=%b done=%b idx=%h addr=%h data=%h required idx=09 data=00",
                 a, tbl_wr_en, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data);
      end
      tick();
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    logic [27:0] obs, exp;
    int n_done = 0;
    send_req(1'b0, 6'd42, 40'h0000000000, 40'h00000000FF);
    repeat (12) tick();
    n_chk++;
    if (tbl_wr_addr !== 5'd12 || tbl_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_reset: addr=%h en=%b required addr=0c en=1", tbl_wr_addr, tbl_wr_en);
    end
    rst = 1'b1;
    tick();
    obs = {tbl_wr_en, lkp_block, req_ready, done, tbl_wr_idx, tbl_wr_addr, tbl_wr_data};
    exp = {1'b0, 1'b0, RDY_AFTER_RST, 1'b0, 6'd0, 5'd0, 8'd0};
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %h required %h", obs, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    n_chk++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: done pulses=%0d required 0", n_done);
    end
    send_req(1'b0, 6'd7, 40'h0000000000, 40'h0000000000);
    n_chk++;
    if ({tbl_wr_en, tbl_wr_idx, tbl_wr_addr, tbl_wr_data} !== {1'b1, 6'd7, 5'd0, 8'hFF}) begin
      n_fail++;
      $display("FAIL mid_reset_new_req: en=%b idx=%h addr=%h data=%h required en=1 idx=07 addr=00 data=ff",
               tbl_wr_en, tbl_wr_idx, tbl_wr_addr, tbl_wr_data);
    end
    repeat (34) tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_idx   = '0;
    req_key   = '0;
    req_mask  = '0;
    test_reset();
`ifdef FRACTCAM_INIT_CLEAR_EN
    test_init_clear();
`endif
    test_write_single();
    test_write_halfmask();
    test_write_exact();
    test_delete();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
